ent_decoder_multi_bit: RTL and testbench

//   Reverse path of the EN-T operand encoder. Takes a native 9-bit EN-T word from local memory/RF and reconstructs the
//   8-bit two's-complement operand. Used for read-back, debug dump and result forwarding to non-EN-T consumers.
//   2-stage pipeline with valid/ready back-pressure, sitting between the tensorcore local RF and the host/readout path.

---
 rtl/ent_decoder_multi_bit_pkg.sv | 40 ++++
 rtl/ent_decoder_multi_bit_if.sv | 26 ++
 rtl/ent_decoder_multi_bit_digit_sum.sv | 28 ++
 rtl/ent_decoder_multi_bit.sv | 117 +++++++++++
 tb/tb_ent_decoder_multi_bit.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ent_decoder_multi_bit_pkg.sv
// Shared EN-T definitions (package ent_pkg).
//   ENT_WIDTH      decoded operand width (two's complement)
//   ENT_EN_WIDTH   EN-T word width: sign bit + radix-4 digit field
//   ENT_DIGITS     number of 2-bit radix-4 digit codes
//   ENT_MAG_WIDTH  width of the signed magnitude produced by the digit sum
//   ent_word_t     EN-T word layout {sign, digits}
//   ent_digit_val  digit code -> signed digit value
package ent_pkg;

    localparam int unsigned ENT_WIDTH     = 8;
    localparam int unsigned ENT_EN_WIDTH  = ENT_WIDTH + 1;
    localparam int unsigned ENT_DIGITS    = (ENT_WIDTH - 1) / 2 + (ENT_WIDTH - 1) % 2;
    localparam int unsigned ENT_MAG_WIDTH = ENT_WIDTH + 1;

    typedef enum logic [1:0] {
        DIG_ZERO = 2'd0,
        DIG_P1   = 2'd1,
        DIG_P2   = 2'd2,
        DIG_M1   = 2'd3
    } ent_code_e;

    typedef struct packed {
        logic                      sign;
        logic [2*ENT_DIGITS-1:0]   digits;
    } ent_word_t;

    function automatic logic signed [2:0] ent_digit_val(input logic [1:0] code);
        logic signed [2:0] v;
        v = '0;
        case (ent_code_e'(code))
            DIG_ZERO: v = 3'sd0;
            DIG_P1:   v = 3'sd1;
            DIG_P2:   v = 3'sd2;
            DIG_M1:   v = -3'sd1;
            default:  v = 3'sd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ent_decoder_multi_bit_if.sv
// EN-T decoder stream interface.
//   en_in / en_in_valid / en_in_ready   EN-T word input handshake
//   dec_out / dec_valid / dec_ready     decoded operand output handshake
//   dec_err                             illegal-word flag travelling with dec_out
// Modports: master = producer/consumer side (testbench, RF, readout), slave = decoder.
interface ent_decoder_multi_bit_if
    import ent_pkg::*;
;
    logic [ENT_EN_WIDTH-1:0] en_in;
    logic                    en_in_valid;
    logic                    en_in_ready;
    logic [ENT_WIDTH-1:0]    dec_out;
    logic                    dec_valid;
    logic                    dec_ready;
    logic                    dec_err;

    modport master (
        output en_in, en_in_valid, dec_ready,
        input  en_in_ready, dec_out, dec_valid, dec_err
    );

    modport slave (
        input  en_in, en_in_valid, dec_ready,
        output en_in_ready, dec_out, dec_valid, dec_err
    );
endinterface

// File: rtl/ent_decoder_multi_bit_digit_sum.sv
// ent_digit_sum: combinational radix-4 digit field to signed magnitude.
//   digits  in   2*DIGITS   digit codes, [2i+1:2i] = digit i
//   mag     out  MAG_WIDTH  signed sum of d_i * 4^i
module ent_digit_sum
    import ent_pkg::*;
#(
    parameter int unsigned DIGITS    = ENT_DIGITS,
    parameter int unsigned MAG_WIDTH = ENT_MAG_WIDTH
) (
    input  logic [2*DIGITS-1:0]          digits,
    output logic signed [MAG_WIDTH-1:0]  mag
);

    always_comb begin
        logic signed [2:0]           v;
        logic signed [MAG_WIDTH-1:0] term;
        v    = '0;
        term = '0;
        mag  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            v    = ent_digit_val(digits[2*i +: 2]);
            // sign-extend the digit, then weight it by 4^i
            term = {{(MAG_WIDTH-3){v[2]}}, v} << (2*i);
            mag  = mag + term;
        end
    end

endmodule

// File: rtl/ent_decoder_multi_bit.sv
// ent_decoder_multi_bit: EN-T word -> 8-bit two's-complement operand.
// Two-stage valid/ready pipeline (S1: digit sum, S2: sign apply), 1 word/cycle,
// 2-cycle latency, synchronous active-high reset.
//   clk, rst   clock, synchronous active-high reset
//   bus        ent_decoder_multi_bit_if.slave (en_in*, dec_out/dec_valid/dec_ready/dec_err)
// Optional: define ENT_DEC_CHECK_EN to build the illegal-word check; otherwise dec_err is tied 0.
module ent_decoder_multi_bit
    import ent_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    ent_decoder_multi_bit_if.slave  bus
);

    localparam int unsigned WIDTH     = ENT_WIDTH;
    localparam int unsigned DIGITS    = ENT_DIGITS;
    localparam int unsigned MAG_WIDTH = ENT_MAG_WIDTH;

    ent_word_t                    word_in;
    logic signed [MAG_WIDTH-1:0]  mag_in;

    logic                         s1_v;
    logic                         s1_sign;
    logic signed [MAG_WIDTH-1:0]  s1_mag;
    logic                         s2_v;
    logic [WIDTH-1:0]             s2_out;
    logic [WIDTH-1:0]             dec_val;

    logic                         s1_adv;
    logic                         s2_adv;

    assign word_in = ent_word_t'(bus.en_in);

    ent_digit_sum #(
        .DIGITS    (DIGITS),
        .MAG_WIDTH (MAG_WIDTH)
    ) u_digit_sum (
        .digits (word_in.digits),
        .mag    (mag_in)
    );

    // Ready depends only on stage occupancy and dec_ready, never on en_in_valid.
    assign s2_adv          = !s2_v || bus.dec_ready;
    assign s1_adv          = !s1_v || s2_adv;
    assign bus.en_in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
        end else if (s1_adv) begin
            s1_v <= bus.en_in_valid;
            if (bus.en_in_valid) begin
                s1_sign <= word_in.sign;
                s1_mag  <= mag_in;
            end
        end
    end

    // Truncation to WIDTH gives the modulo-2^WIDTH wrap for out-of-range magnitudes.
    always_comb begin
        dec_val = s1_sign ? WIDTH'(-s1_mag) : WIDTH'(s1_mag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v   <= 1'b0;
            s2_out <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_out <= dec_val;
            end
        end
    end

    assign bus.dec_valid = s2_v;
    assign bus.dec_out   = s2_out;

`ifdef ENT_DEC_CHECK_EN
    localparam logic signed [MAG_WIDTH-1:0] MAG_FULL = MAG_WIDTH'(1 << (WIDTH - 1));

    logic err_in;
    logic s1_err;
    logic s2_err;

    always_comb begin
        err_in = (ent_code_e'(word_in.digits[2*DIGITS-1 -: 2]) == DIG_M1)
              || mag_in[MAG_WIDTH-1]
              || (mag_in > MAG_FULL)
              || (!word_in.sign && (mag_in == MAG_FULL))
              || ( word_in.sign && (mag_in == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err <= 1'b0;
        end else if (s1_adv && bus.en_in_valid) begin
            s1_err <= err_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_err <= 1'b0;
        end else if (s2_adv && s1_v) begin
            s2_err <= s1_err;
        end
    end

    assign bus.dec_err = s2_err;
`else
    assign bus.dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_ent_decoder_multi_bit.sv
// Self-checking bench for ent_decoder_multi_bit: directed, exhaustive round-trip,
// random words, stall/back-pressure, illegal-word flag and mid-flight reset.
module tb_ent_decoder_multi_bit;

    logic clk;
    logic rst;

    ent_decoder_multi_bit_if bus ();

    ent_decoder_multi_bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef ENT_DEC_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    int n_checks;
    int n_fail;

    logic [8:0] in_q  [$];
    logic [7:0] out_q [$];
    logic       err_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode straight from the digit map: sum of d_i*4^i, negate if sign, wrap mod 256.
    function automatic logic [7:0] model_dec(input logic [8:0] w);
        int mag;
        int d;
        mag = 0;
        for (int i = 0; i < 4; i++) begin
            d = int'(w[2*i +: 2]);
            if (d == 3) d = -1;
            mag = mag + d * (1 << (2*i));
        end
        if (w[8]) mag = -mag;
        return 8'(mag);
    endfunction

    function automatic logic model_err(input logic [8:0] w);
        int mag;
        int d;
        logic [1:0] top;
        mag = 0;
        top = w[7:6];
        for (int i = 0; i < 4; i++) begin
            d = int'(w[2*i +: 2]);
            if (d == 3) d = -1;
            mag = mag + d * (1 << (2*i));
        end
        return CHECK_ON && ((top == 2'd3) || (mag < 0) || (mag > 128)
                            || (!w[8] && mag == 128) || (w[8] && mag == 0));
    endfunction

    // Behavioural EN-T encoder: sign + |x|, greedy radix-4 digits in {-1,0,1,2}.
    function automatic logic [8:0] model_enc(input int x);
        logic [8:0] w;
        int m;
        int r;
        w    = '0;
        w[8] = (x < 0);
        m    = (x < 0) ? -x : x;
        for (int i = 0; i < 4; i++) begin
            r = m % 4;
            if (r == 3) begin
                w[2*i +: 2] = 2'd3;
                m = (m + 1) / 4;
            end else begin
                w[2*i +: 2] = 2'(r);
                m = m / 4;
            end
        end
        return w;
    endfunction

    // Streams in_q through the DUT with random valid/ready; collects outputs in order.
    task automatic run_stream(input int ready_pct, input int valid_pct, output bit timed_out);
        int sent;
        int cyc;
        int budget;
        sent      = 0;
        cyc       = 0;
        budget    = 20 * in_q.size() + 50;
        timed_out = 1'b0;
        out_q.delete();
        err_q.delete();
        while (out_q.size() < in_q.size()) begin
            @(negedge clk);
            bus.dec_ready = ($urandom_range(99) < ready_pct);
            if (sent < in_q.size() && $urandom_range(99) < valid_pct) begin
                bus.en_in_valid = 1'b1;
                bus.en_in       = in_q[sent];
            end else begin
                bus.en_in_valid = 1'b0;
                bus.en_in       = 9'($urandom);
            end
            #1;
            if (bus.en_in_valid && bus.en_in_ready) sent++;
            if (bus.dec_valid && bus.dec_ready) begin
                out_q.push_back(bus.dec_out);
                err_q.push_back(bus.dec_err);
            end
            cyc++;
            if (cyc > budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(negedge clk);
        bus.en_in_valid = 1'b0;
        bus.dec_ready   = 1'b1;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.en_in_valid = 1'b0;
        bus.en_in       = '0;
        bus.dec_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.dec_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid);
        end
        n_checks++;
        if (bus.dec_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_dec_out: got %h want 00", bus.dec_out);
        end
        n_checks++;
        if (bus.dec_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_dec_err: got %b want 0", bus.dec_err);
        end
        n_checks++;
        if (bus.en_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_en_in_ready: got %b want 1", bus.en_in_ready);
        end
    endtask

    task automatic test_directed();
        logic [8:0] w [3] = '{9'h083, 9'h007, 9'h000};
        logic [7:0] e [3] = '{8'h7F, 8'h03, 8'h00};
        logic       exp_v;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.dec_ready = 1'b1;
            if (c < 3) begin
                bus.en_in_valid = 1'b1;
                bus.en_in       = w[c];
            end else begin
                bus.en_in_valid = 1'b0;
                bus.en_in       = '0;
            end
            #1;
            if (c < 3) begin
                n_checks++;
                if (bus.en_in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL directed_ready c=%0d: got %b want 1", c, bus.en_in_ready);
                end
            end
            exp_v = (c >= 2 && c < 5);
            n_checks++;
            if (bus.dec_valid !== exp_v) begin
                n_fail++; $display("FAIL directed_valid c=%0d: got %b want %b", c, bus.dec_valid, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (bus.dec_out !== e[c-2]) begin
                    n_fail++; $display("FAIL directed_out c=%0d: got %h want %h", c, bus.dec_out, e[c-2]);
                end
            end
        end
        bus.en_in_valid = 1'b0;
    endtask

    task automatic test_negative();
        bit to;
        logic [7:0] e [2] = '{8'hFF, 8'h80};
        in_q = '{9'h101, 9'h180};
        run_stream(100, 100, to);
        n_checks++;
        if (to || out_q.size() != 2) begin
            n_fail++; $display("FAIL negative_count: got %0d words want 2", out_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (out_q[i] !== e[i] || err_q[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL negative_word %0d: got %h/err %b want %h/err 0", i, out_q[i], err_q[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_exhaustive();
        bit to;
        in_q.delete();
        for (int x = -128; x < 128; x++) in_q.push_back(model_enc(x));
        run_stream(70, 80, to);
        n_checks++;
        if (to || out_q.size() != 256) begin
            n_fail++; $display("FAIL exhaustive_count: got %0d words want 256", out_q.size());
        end else begin
            for (int x = -128; x < 128; x++) begin
                n_checks++;
                if (out_q[x+128] !== 8'(x) || err_q[x+128] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL exhaustive x=%0d: got %h/err %b want %h/err 0",
                             x, out_q[x+128], err_q[x+128], 8'(x));
                end
            end
        end
    endtask

    task automatic test_random_words();
        bit to;
        in_q.delete();
        for (int i = 0; i < 200; i++) in_q.push_back(9'($urandom));
        run_stream(60, 70, to);
        n_checks++;
        if (to || out_q.size() != 200) begin
            n_fail++; $display("FAIL random_count: got %0d words want 200", out_q.size());
        end else begin
            for (int i = 0; i < 200; i++) begin
                n_checks++;
                if (out_q[i] !== model_dec(in_q[i]) || err_q[i] !== model_err(in_q[i])) begin
                    n_fail++;
                    $display("FAIL random_word %0d in=%h: got %h/err %b want %h/err %b", i, in_q[i],
                             out_q[i], err_q[i], model_dec(in_q[i]), model_err(in_q[i]));
                end
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [8:0] words [5];
        logic [7:0] exp   [5];
        logic [7:0] got   [$];
        logic [7:0] held;
        bit         have;
        int         sent;
        int         cyc;
        int         x;
        for (int i = 0; i < 5; i++) begin
            x        = int'($urandom_range(255)) - 128;
            words[i] = model_enc(x);
            exp[i]   = 8'(x);
        end
        sent = 0;
        have = 1'b0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.dec_ready   = 1'b0;
            bus.en_in_valid = 1'b1;
            bus.en_in       = words[sent];
            #1;
            if (bus.dec_valid) begin
                if (!have) begin
                    held = bus.dec_out;
                    have = 1'b1;
                end else begin
                    n_checks++;
                    if (bus.dec_out !== held) begin
                        n_fail++; $display("FAIL stall_hold c=%0d: got %h want %h", c, bus.dec_out, held);
                    end
                end
            end
            if (bus.en_in_ready) sent++;
        end
        n_checks++;
        if (sent != 2) begin
            n_fail++; $display("FAIL stall_accepts: got %0d want 2", sent);
        end
        n_checks++;
        if (bus.en_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_ready: got %b want 0", bus.en_in_ready);
        end
        n_checks++;
        if (!have || held !== exp[0]) begin
            n_fail++; $display("FAIL stall_head: got %h (seen %b) want %h", held, have, exp[0]);
        end
        cyc = 0;
        while (got.size() < 5 && cyc < 100) begin
            @(negedge clk);
            bus.dec_ready = 1'b1;
            if (sent < 5) begin
                bus.en_in_valid = 1'b1;
                bus.en_in       = words[sent];
            end else begin
                bus.en_in_valid = 1'b0;
            end
            #1;
            if (cyc == 0) begin
                n_checks++;
                if (bus.en_in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL release_ready: got %b want 1", bus.en_in_ready);
                end
            end
            if (bus.en_in_valid && bus.en_in_ready) sent++;
            if (bus.dec_valid) got.push_back(bus.dec_out);
            cyc++;
        end
        bus.en_in_valid = 1'b0;
        n_checks++;
        if (got.size() != 5) begin
            n_fail++; $display("FAIL release_count: got %0d want 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got[i] !== exp[i]) begin
                    n_fail++; $display("FAIL release_order %0d: got %h want %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_illegal_flag();
        bit to;
        logic [7:0] e_out [3] = '{8'h00, 8'hC0, 8'h7F};
        logic       e_err [3];
        e_err = '{CHECK_ON, CHECK_ON, 1'b0};
        in_q  = '{9'h100, 9'h0C0, 9'h083};
        run_stream(100, 100, to);
        n_checks++;
        if (to || out_q.size() != 3) begin
            n_fail++; $display("FAIL illegal_count: got %0d words want 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (out_q[i] !== e_out[i] || err_q[i] !== e_err[i]) begin
                    n_fail++;
                    $display("FAIL illegal_word %0d: got %h/err %b want %h/err %b",
                             i, out_q[i], err_q[i], e_out[i], e_err[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit to;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.dec_ready   = 1'b0;
            bus.en_in_valid = 1'b1;
            bus.en_in       = model_enc(int'($urandom_range(100)) + 1);
        end
        @(negedge clk);
        bus.en_in_valid = 1'b0;
        rst             = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.dec_valid !== 1'b0 || bus.dec_out !== 8'h00) begin
            n_fail++; $display("FAIL midreset_out: got valid %b out %h want 0/00", bus.dec_valid, bus.dec_out);
        end
        n_checks++;
        if (bus.en_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_ready: got %b want 1", bus.en_in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.dec_ready = 1'b1;
            #1;
            n_checks++;
            if (bus.dec_valid !== 1'b0) begin
                n_fail++; $display("FAIL midreset_stale c=%0d: got %b want 0", c, bus.dec_valid);
            end
        end
        in_q = '{model_enc(-77)};
        run_stream(100, 100, to);
        n_checks++;
        if (to || out_q.size() != 1 || out_q[0] !== 8'(-77)) begin
            n_fail++; $display("FAIL midreset_resume: got %0d words first %h want 1 word b3",
                               out_q.size(), (out_q.size() > 0) ? out_q[0] : 8'h00);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_negative();
        test_exhaustive();
        test_random_words();
        test_back_to_back_stall();
        test_illegal_flag();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
